// File: rtl/seq_pkg.sv
// Shared definitions for the serial bit source and the sequence detector
// bench: FSM state encoding and the default word width.
package seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_PARITY = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/piso_shift_reg.sv
// Load/shift register for the serial bit source. Exposes the MSB that the
// register will hold after this edge, so the top can register x directly.
// Optional macro SERIAL_BIT_SOURCE_PARITY_EN adds a parity bit captured at load.
module piso_shift_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] din,
    output logic             msb_next
`ifdef SERIAL_BIT_SOURCE_PARITY_EN
    ,
    output logic             parity
`endif
);

    logic [WIDTH-1:0] sr_q;
    logic [WIDTH-1:0] sr_d;

    // Next register value: load wins over shift; MSB-first, zero fill.
    always_comb begin
        sr_d = sr_q;
        if (load) begin
            sr_d = din;
        end else if (shift) begin
            sr_d = sr_q << 1;
        end
    end

    // Shift register storage.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign msb_next = sr_d[WIDTH-1];

`ifdef SERIAL_BIT_SOURCE_PARITY_EN
    logic parity_q;
    logic parity_d;

    // Even parity of the whole word, captured before any bit is shifted out.
    always_comb begin
        parity_d = parity_q;
        if (load) begin
            parity_d = ^din;
        end
    end

    // Parity storage.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= parity_d;
        end
    end

    assign parity = parity_q;
`endif

endmodule

// File: rtl/serial_bit_source.sv
// Parallel-to-serial front end: accepts words over valid/ready and emits
// them MSB-first with x_valid, streaming back-to-back words without a gap.
// Optional macro SERIAL_BIT_SOURCE_PARITY_EN appends an even-parity bit.
module serial_bit_source
    import seq_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             x,
    output logic             x_valid,
    output logic             busy,
    output logic [CNT_W-1:0] word_count
);

    localparam int BC_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [BC_W-1:0] LAST_IDX = BC_W'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [BC_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0] word_count_q, word_count_d;
    logic             x_q, x_d;
    logic             x_valid_q, x_valid_d;
    logic             busy_q, busy_d;
    logic             ready_c;
    logic             load;
    logic             shift;
    logic             msb_next;
`ifdef SERIAL_BIT_SOURCE_PARITY_EN
    logic             parity;
`endif

    piso_shift_reg #(.WIDTH(WIDTH)) u_sr (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .shift    (shift),
        .din      (din),
        .msb_next (msb_next)
`ifdef SERIAL_BIT_SOURCE_PARITY_EN
        ,
        .parity   (parity)
`endif
    );

    // Next-state, handshake and counter logic; outputs precomputed for the next cycle.
    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        word_count_d = word_count_q;
        ready_c      = 1'b0;
        load         = 1'b0;
        shift        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                ready_c = 1'b1;
                if (din_valid) begin
                    load      = 1'b1;
                    bit_cnt_d = LAST_IDX;
                    state_d   = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (bit_cnt_q != '0) begin
                    shift     = 1'b1;
                    bit_cnt_d = bit_cnt_q - BC_W'(1);
                end else begin
`ifdef SERIAL_BIT_SOURCE_PARITY_EN
                    state_d = ST_PARITY;
`else
                    ready_c      = 1'b1;
                    word_count_d = word_count_q + CNT_W'(1);
                    if (din_valid) begin
                        load      = 1'b1;
                        bit_cnt_d = LAST_IDX;
                    end else begin
                        state_d = ST_IDLE;
                    end
`endif
                end
            end
`ifdef SERIAL_BIT_SOURCE_PARITY_EN
            ST_PARITY: begin
                ready_c      = 1'b1;
                word_count_d = word_count_q + CNT_W'(1);
                if (din_valid) begin
                    load      = 1'b1;
                    bit_cnt_d = LAST_IDX;
                    state_d   = ST_SHIFT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        x_d = 1'b0;
        if (state_d == ST_SHIFT) begin
            x_d = msb_next;
        end
`ifdef SERIAL_BIT_SOURCE_PARITY_EN
        else if (state_d == ST_PARITY) begin
            x_d = parity;
        end
`endif
        x_valid_d = (state_d != ST_IDLE);
        busy_d    = (state_d != ST_IDLE);
    end

    // State, counters and registered serial outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            bit_cnt_q    <= '0;
            word_count_q <= '0;
            x_q          <= 1'b0;
            x_valid_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            word_count_q <= word_count_d;
            x_q          <= x_d;
            x_valid_q    <= x_valid_d;
            busy_q       <= busy_d;
        end
    end

    assign din_ready  = ready_c & reset;
    assign x          = x_q;
    assign x_valid    = x_valid_q;
    assign busy       = busy_q;
    assign word_count = word_count_q;

endmodule
